word_split_16: RTL and testbench

- Reverse path of the 16-to-32 zero-extension datapath. Takes 32-bit words and emits them as a stream of 16-bit halfwords.
- Optional compression: when the word's upper half is zero, only the low halfword is sent. The downstream side rebuilds the word by zero-extension.
- Sits between the 32-bit register/bus side and any 16-bit consumer (halfword store path, 16-bit display/UART framing).
- Valid/ready handshake on both sides; output is fully registered.

---
 rtl/word_split_16.sv | 106 ++++++++++
 tb/tb_word_split_16.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_split_16.sv
// Splits 32-bit words into a registered stream of 16-bit halfwords, with
// optional single-beat send for words whose upper half is zero.
module word_split_16 #(
  parameter int LOW_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             compress,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             out_zext,
  output logic [CNT_W-1:0] word_cnt
);

  // state  | meaning
  // IDLE   | output empty
  // FIRST  | first of two beats presented
  // SECOND | second beat presented
  // SINGLE | only beat of a compressed word presented
  typedef enum logic [1:0] {IDLE, FIRST, SECOND, SINGLE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [15:0]      data_d;
  logic             last_d, zext_d, valid_d;
  logic [CNT_W-1:0] cnt_d;
  logic             beat, accept, zf;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    data_d   = out_data;
    last_d   = out_last;
    zext_d   = out_zext;
    valid_d  = out_valid;
    cnt_d    = word_cnt;
    beat     = out_valid & out_ready;
    in_ready = (state_q == IDLE) |
               (((state_q == SECOND) | (state_q == SINGLE)) & out_ready);
    accept   = in_valid & in_ready;
    zf       = (in_data[31:16] == 16'h0);

    case (state_q)
      FIRST: begin
        if (beat) begin
          state_d = SECOND;
          data_d  = (LOW_FIRST != 0) ? word_q[31:16] : word_q[15:0];
          last_d  = 1'b1;
        end
      end
      SECOND, SINGLE: begin
        if (beat) begin
          cnt_d = word_cnt + CNT_W'(1);
          if (!accept) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: ;
    endcase

    // A new word overrides the idle transition above, giving zero-bubble reloads.
    if (accept) begin
      word_d  = in_data;
      zext_d  = zf;
      valid_d = 1'b1;
      if (compress & zf) begin
        state_d = SINGLE;
        data_d  = in_data[15:0];
        last_d  = 1'b1;
      end else begin
        state_d = FIRST;
        data_d  = (LOW_FIRST != 0) ? in_data[15:0] : in_data[31:16];
        last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_zext  <= 1'b0;
      out_valid <= 1'b0;
      word_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      out_data  <= data_d;
      out_last  <= last_d;
      out_zext  <= zext_d;
      out_valid <= valid_d;
      word_cnt  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_word_split_16.sv
// Bench for word_split_16: scoreboard of expected beats for the default
// instance, plus a LOW_FIRST=0 / CNT_W=2 instance checked inline.
module tb_word_split_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, compress, out_valid, out_ready, out_last, out_zext;
  logic [31:0] in_data;
  logic [15:0] out_data;
  logic [7:0]  word_cnt;

  logic        a_in_valid, a_in_ready, a_compress, a_out_valid, a_out_ready, a_out_last, a_out_zext;
  logic [31:0] a_in_data;
  logic [15:0] a_out_data;
  logic [1:0]  a_word_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_cnt = 0;
  logic [17:0] exp_q[$];
  int beat_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  word_split_16 #(.LOW_FIRST(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .compress(compress), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_zext(out_zext), .word_cnt(word_cnt));

  word_split_16 #(.LOW_FIRST(0), .CNT_W(2)) u_alt (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .compress(a_compress), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .out_zext(a_out_zext), .word_cnt(a_word_cnt));

  // Scoreboard consumer: every handshaken beat must match the oldest expectation.
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst_n && out_valid && out_ready) begin
      beat_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got data=%h last=%b zext=%b", out_data, out_last, out_zext);
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_last, out_zext} !== e) begin
          errors++;
          $display("FAIL beat got data=%h last=%b zext=%b want data=%h last=%b zext=%b",
                   out_data, out_last, out_zext, e[17:2], e[1], e[0]);
        end
        if (e[1]) exp_cnt = exp_cnt + 1;
      end
    end
  end

  task automatic push_expected(input logic [31:0] d, input logic c);
    logic z;
    z = (d[31:16] == 16'h0);
    if (c && z) exp_q.push_back({d[15:0], 1'b1, z});
    else begin
      exp_q.push_back({d[15:0], 1'b0, z});
      exp_q.push_back({d[31:16], 1'b1, z});
    end
  endtask

  // Presents a word and returns one tick after the accepting edge; in_valid stays high.
  task automatic send_word(input logic [31:0] d, input logic c);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    compress = c;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got in_ready=%b want 1", in_ready);
        break;
      end
    end
    push_expected(d, c);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (out_valid || exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout got out_valid=%b pending=%0d want 0", out_valid, exp_q.size());
        break;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (word_cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL word_cnt got %0d want %0d", word_cnt, 8'(exp_cnt));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 32'hFFFF_FFFF; compress = 1'b0; out_ready = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_compress = 1'b0; a_out_ready = 1'b1;
    #3;
    checks++;
    if ({out_valid, out_data, out_last, out_zext, word_cnt, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h l=%b z=%b cnt=%0d rdy=%b want 0/0000/0/0/0/1",
               out_valid, out_data, out_last, out_zext, word_cnt, in_ready);
    end
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    send_word(32'h1234_ABCD, 1'b0);
    wait_idle();
  endtask

  task automatic test_zext();
    send_word(32'h0000_5A5A, 1'b1);
    wait_idle();
    send_word(32'h0000_5A5A, 1'b0);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = beat_cyc.size();
    send_word(32'h0000_0001, 1'b1);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_word(32'h0000_0001, 1'b1);
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_idle();
    checks++;
    if (beat_cyc.size() - n0 != 6) begin
      errors++;
      $display("FAIL b2b_beats got %0d want 6", beat_cyc.size() - n0);
    end else begin
      checks++;
      if (beat_cyc[n0+5] - beat_cyc[n0] != 5) begin
        errors++;
        $display("FAIL b2b_span got %0d cycles want 5", beat_cyc[n0+5] - beat_cyc[n0]);
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send_word(32'hCAFE_F00D, 1'b0);
    in_valid = 1'b0;
    in_data  = 32'h1111_2222;
    compress = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, out_last, in_ready} !== {1'b1, 16'hF00D, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall got v=%b d=%h l=%b rdy=%b want 1/f00d/0/0",
                 out_valid, out_data, out_last, in_ready);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_word(32'h5555_6666, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_last, word_cnt} !== {1'b0, 16'h0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset_mid got v=%b d=%h l=%b cnt=%0d want 0/0000/0/0",
               out_valid, out_data, out_last, word_cnt);
    end
    exp_q.delete();
    exp_cnt = 0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL post_reset got v=%b rdy=%b want 0/1", out_valid, in_ready);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alt();
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h1234_ABCD;
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL alt_ready got %b want 1", a_in_ready);
      end
      @(posedge clk);
      #1 a_in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({a_out_valid, a_out_data, a_out_last} !== {1'b1, 16'h1234, 1'b0}) begin
        errors++;
        $display("FAIL alt_first got v=%b d=%h l=%b want 1/1234/0", a_out_valid, a_out_data, a_out_last);
      end
      @(negedge clk);
      checks++;
      if ({a_out_valid, a_out_data, a_out_last} !== {1'b1, 16'hABCD, 1'b1}) begin
        errors++;
        $display("FAIL alt_second got v=%b d=%h l=%b want 1/abcd/1", a_out_valid, a_out_data, a_out_last);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({a_out_valid, a_word_cnt} !== {1'b0, 2'((i + 1) % 4)}) begin
        errors++;
        $display("FAIL alt_cnt got v=%b cnt=%0d want 0/%0d", a_out_valid, a_word_cnt, (i + 1) % 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zext();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_alt();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_beats got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
